// File: rtl/irq_ctrl_pkg.sv
// Shared register map, CTRL bit positions and the priority-encode helper for irq_ctrl.
package irq_ctrl_pkg;

  localparam logic [1:0] IRQ_PEND = 2'd0;
  localparam logic [1:0] IRQ_MASK = 2'd1;
  localparam logic [1:0] IRQ_MODE = 2'd2;
  localparam logic [1:0] IRQ_CTRL = 2'd3;

  localparam int unsigned CTRL_GIE_BIT = 0;
  localparam int unsigned CTRL_ID_LSB  = 8;
  localparam int unsigned CTRL_INT_BIT = 31;

  // Index of the lowest set bit; index 0 is the highest priority.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_ctrl_sync.sv
// Multi-flop synchroniser for one event line, plus a one-clock rising-edge strobe.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic                   prev_d, prev_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
    lvl    = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Bus-mapped interrupt controller: per-source sync/latch, mask, global enable,
// registered INT and priority ID to the CPU.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [N_SRC-1:0] irq_src,
  output logic             int_o,
  output logic [2:0]       int_id
);

  logic [N_SRC-1:0] s, rise, clr, act;
  logic [N_SRC-1:0] pending_d, pending_q;
  logic [N_SRC-1:0] mask_d, mask_q;
  logic [N_SRC-1:0] mode_d, mode_q;
  logic             gie_d, gie_q;
  logic             int_o_d, int_o_q;
  logic [2:0]       int_id_d, int_id_q;
  logic             wr;
  logic             unused_wdata;

  assign unused_wdata = ^wdata;

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (irq_src[k]),
      .lvl  (s[k]),
      .rise (rise[k])
    );
  end

  always_comb begin
    wr     = we & sel;
    clr    = '0;
    mask_d = mask_q;
    mode_d = mode_q;
    gie_d  = gie_q;
    if (wr) begin
      case (addr)
        IRQ_PEND: clr    = wdata[N_SRC-1:0];
        IRQ_MASK: mask_d = wdata[N_SRC-1:0];
        IRQ_MODE: mode_d = wdata[N_SRC-1:0];
        default:  gie_d  = wdata[CTRL_GIE_BIT];
      endcase
    end
    // Edge bits: a rise in the same clock as a W1C wins, so no event is lost.
    pending_d = (mode_q & s) | (~mode_q & ((pending_q & ~clr) | rise));
    act       = pending_q & mask_q;
    int_o_d   = gie_q & (|act);
    int_id_d  = (|act) ? lowest_set(8'(act)) : int_id_q;
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        IRQ_PEND: rdata[N_SRC-1:0] = pending_q;
        IRQ_MASK: rdata[N_SRC-1:0] = mask_q;
        IRQ_MODE: rdata[N_SRC-1:0] = mode_q;
        default: begin
          rdata[CTRL_GIE_BIT]         = gie_q;
          rdata[CTRL_ID_LSB +: 3]     = int_id_q;
          rdata[CTRL_INT_BIT]         = int_o_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      gie_q     <= 1'b0;
      int_o_q   <= 1'b0;
      int_id_q  <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      gie_q     <= gie_d;
      int_o_q   <= int_o_d;
      int_id_q  <= int_id_d;
    end
  end

  assign int_o  = int_o_q;
  assign int_id = int_id_q;

endmodule
